uart_word_receiver: RTL and testbench
=====================================

Name: uart_word_receiver

Overview:
Receive end of the 16-bit UART channel. Recovers serial frames from RxD, checks parity and stop bit, and reassembles two consecutive byte frames, low byte first, into one 16-bit word. For example, digits 0,1,C,C on the transmit side produce the word 0xCC10. Sits between the board RxD pin and the display/consumer logic, at the same baud setting as the transmitter.

Parameters:
GAP_BITS, 32, maximum idle gap between the low-byte and high-byte frames, in bit times, before the held low byte is discarded
SYNC_STAGES, 2, number of flip-flops in the RxD synchronizer

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
baud_select  in  3  baud rate index 0..7
RX_EN  in  1  receiver enable
RxD  in  1  serial input, idles high
data  out  16  last complete word
word_valid  out  1  one-cycle pulse when data updates
Rx_PERROR  out  1  one-cycle pulse on parity error
Rx_FERROR  out  1  one-cycle pulse on framing error
busy  out  1  high while a frame is in progress, or while a low byte is held

Behaviour:
- Reset: one synchronous, active-high reset in a single clock domain. All outputs reset to 0. FSM goes to IDLE, the low-byte holder is cleared, and the synchronizer flops reset to 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, even parity (over data plus parity bit, XOR = 0), 1 stop bit (1).
- Oversampling: 16x. Tick divisor values for baud_select 0..7 (300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud) are 10415, 2603, 650, 325, 162, 80, 53, 26. The tick counter counts 0..div and wraps.
- baud_select is latched on the IDLE->START transition. Changes while not in IDLE are ignored until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronized 1->0 edge while RX_EN=1.
  - START: at tick 8, if the sample is still 0 go to DATA; otherwise treat as a false start and return to IDLE with no flags.
  - DATA: sample 8 bits, one sample per 16 ticks, at mid-bit.
  - PARITY: sample the parity bit.
  - STOP: sample at mid-bit, then return to IDLE.
- Frame end cycle (the cycle after the stop sample):
  - Parity mismatch: pulse Rx_PERROR.
  - Stop bit = 0: pulse Rx_FERROR.
  - Both conditions: both flags pulse in the same cycle.
  - Any error: the frame is dropped and the held low byte is cleared.
- Word assembly:
  - A good frame with no low byte held is stored as the low byte.
  - A good frame with a low byte held: data <= {frame, low}, word_valid pulses in the same cycle as the data update, and the holder clears.
  - Latency: word_valid rises 1 clk after the mid-stop sample of the second frame.
- Gap timeout: the gap counter runs in bit times (16 ticks) while a low byte is held and the FSM is in IDLE. When the count exceeds GAP_BITS, the low byte is discarded silently.
- RX_EN:
  - RX_EN=0 forces the FSM to IDLE and clears the low-byte holder, aborting any frame in progress with no flags.
  - data keeps its last value.
- A reset mid-frame aborts the frame. The next falling edge after reset is treated as a new start.
- data changes only together with word_valid.

Decomposition:
- Package uart_pkg holds:
  - the baud divisor table as constant function baud_div(sel)
  - the frame FSM state enum
  - the constants OVERSAMPLE=16, MID_SAMPLE=8, DATA_BITS=8
- Sub-module uart_rx_baud_tick: takes clk, reset, baud_select and a restart input, and outputs sample_tick. It restarts its counter on the start edge so that sampling is phase-aligned.

Test Plan:
- Word reassembly: baud_select=7 (432 clk/bit), send frames 0x10 then 0xCC back-to-back -> data=0xCC10, word_valid high exactly 1 cycle, no error pulses.
- Parity error: corrupt the parity bit of frame 0x10 -> one Rx_PERROR pulse, holder cleared. Then a good 0x34,0x12 -> data=0x1234.
- Framing error: stop bit driven 0 on the second byte of 0xAB,0xCD -> Rx_FERROR pulse, no word_valid, data keeps its previous value.
- False start: RxD low for 5 ticks (135 clk at sel 7), then high -> no flags, FSM returns to IDLE, busy=0. The following word 0x5A5A is received correctly.
- Gap timeout: send 0x11, idle 40 bit times, then 0x22,0x33 -> data=0x3322 (not 0x2211), exactly one word_valid.
- Abort paths: RX_EN dropped during DATA of the first byte, then restored and 0xEF,0xBE sent -> data=0xBEEF. Repeat with reset pulsed mid-frame instead -> same result, and all outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, frame FSM states and baud divisor table for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Tick counter terminal value (counts 0..div) giving 16 ticks per bit at 50 MHz.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    baud_div = 14'd10415;
            3'd1:    baud_div = 14'd2603;
            3'd2:    baud_div = 14'd650;
            3'd3:    baud_div = 14'd325;
            3'd4:    baud_div = 14'd162;
            3'd5:    baud_div = 14'd80;
            3'd6:    baud_div = 14'd53;
            default: baud_div = 14'd26;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// 16x oversampling tick generator; restart re-phases the counter to the start edge
// and latches the baud divisor for the whole frame.
module uart_rx_baud_tick
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       sample_tick
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // NOTE: every _d gets a default before any condition, so no latch can be inferred.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q + 1'b1;
        if (restart) begin
            div_d = baud_div(baud_select);
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
        end
    end

    assign sample_tick = (cnt_q == div_q) && !restart;

    // NOTE: flops use <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= baud_div(3'd0);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_receiver.sv
// UART receive end: recovers 8E1 frames from RxD and pairs them, low byte first,
// into 16-bit words with parity/framing error pulses and a low-byte gap timeout.
module uart_word_receiver
    import uart_pkg::*;
#(
    parameter int GAP_BITS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  baud_select,
    input  logic        RX_EN,
    input  logic        RxD,
    output logic [15:0] data,
    output logic        word_valid,
    output logic        Rx_PERROR,
    output logic        Rx_FERROR,
    output logic        busy
);

    localparam int GAP_W = $clog2(GAP_BITS + 1);
    localparam logic [3:0]       TICK_MID  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0]       TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_BITS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_prev_q, rxd_prev_d;
    logic                   rxd_s, rxd_fall;

    rx_state_e              state_q, state_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   held_q, held_d;
    logic [DATA_BITS-1:0]   low_q, low_d;
    logic [3:0]             gap_tick_q, gap_tick_d;
    logic [GAP_W-1:0]       gap_bits_q, gap_bits_d;
    logic [15:0]            data_q, data_d;
    logic                   word_valid_q, word_valid_d;
    logic                   perror_q, perror_d;
    logic                   ferror_q, ferror_d;
    logic                   busy_q, busy_d;

    logic                   restart, sample_tick;
    logic                   par_bad, stop_bad;

    uart_rx_baud_tick u_baud_tick (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .restart     (restart),
        .sample_tick (sample_tick)
    );

    if (SYNC_STAGES > 1) begin : g_sync
        assign sync_d = {sync_q[SYNC_STAGES-2:0], RxD};
    end else begin : g_sync1
        assign sync_d = RxD;
    end

    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign rxd_prev_d = rxd_s;
    assign rxd_fall   = rxd_prev_q & ~rxd_s;
    assign par_bad    = ^{shift_q, parity_q};
    assign stop_bad   = ~rxd_s;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        held_d       = held_q;
        low_d        = low_q;
        gap_tick_d   = '0;
        gap_bits_d   = '0;
        data_d       = data_q;
        word_valid_d = 1'b0;
        perror_d     = 1'b0;
        ferror_d     = 1'b0;
        restart      = 1'b0;

        if (!RX_EN) begin
            state_d = IDLE;
            held_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rxd_fall) begin
                        state_d    = START;
                        restart    = 1'b1;
                        tick_cnt_d = '0;
                    end else if (held_q) begin
                        // Gap timer: whole bit times idle; the held byte is dropped once the count would pass GAP_BITS.
                        gap_tick_d = gap_tick_q;
                        gap_bits_d = gap_bits_q;
                        if (sample_tick) begin
                            gap_tick_d = gap_tick_q + 1'b1;
                            if (gap_tick_q == TICK_LAST) begin
                                if (gap_bits_q == GAP_LIMIT) held_d = 1'b0;
                                else gap_bits_d = gap_bits_q + 1'b1;
                            end
                        end
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                        if (tick_cnt_q == TICK_LAST) begin
                            shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                        if (tick_cnt_q == TICK_LAST) begin
                            parity_d = rxd_s;
                            state_d  = STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                        if (tick_cnt_q == TICK_LAST) begin
                            state_d  = IDLE;
                            perror_d = par_bad;
                            ferror_d = stop_bad;
                            if (par_bad || stop_bad) begin
                                held_d = 1'b0;
                            end else if (held_q) begin
                                data_d       = {shift_q, low_q};
                                word_valid_d = 1'b1;
                                held_d       = 1'b0;
                            end else begin
                                low_d  = shift_q;
                                held_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE) || held_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '1;
            rxd_prev_q   <= 1'b1;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            held_q       <= 1'b0;
            low_q        <= '0;
            gap_tick_q   <= '0;
            gap_bits_q   <= '0;
            data_q       <= '0;
            word_valid_q <= 1'b0;
            perror_q     <= 1'b0;
            ferror_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rxd_prev_q   <= rxd_prev_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            held_q       <= held_d;
            low_q        <= low_d;
            gap_tick_q   <= gap_tick_d;
            gap_bits_q   <= gap_bits_d;
            data_q       <= data_d;
            word_valid_q <= word_valid_d;
            perror_q     <= perror_d;
            ferror_q     <= ferror_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign word_valid = word_valid_q;
    assign Rx_PERROR  = perror_q;
    assign Rx_FERROR  = ferror_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Bench for uart_word_receiver at 115200 baud: a frame-level model tracks the held
// low byte, expected words and error pulse counts; a monitor counts what the DUT emits.
module tb_uart_word_receiver;

    localparam int BIT_CLKS = 432;
    localparam int GAP_BITS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  baud_select;
    logic        RX_EN;
    logic        RxD;
    logic [15:0] data;
    logic        word_valid;
    logic        rx_perror;
    logic        rx_ferror;
    logic        busy;

    always #10 clk = ~clk;

    uart_word_receiver #(
        .GAP_BITS    (GAP_BITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .RX_EN       (RX_EN),
        .RxD         (RxD),
        .data        (data),
        .word_valid  (word_valid),
        .Rx_PERROR   (rx_perror),
        .Rx_FERROR   (rx_ferror),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor.
    int          wv_cnt = 0, pe_cnt = 0, fe_cnt = 0, wv_long = 0, stray_change = 0;
    logic        wv_prev = 1'b0;
    logic [15:0] data_prev = '0;
    logic        rst_seen = 1'b1;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (word_valid) wv_cnt++;
        if (word_valid && wv_prev) wv_long++;
        if (rx_perror) pe_cnt++;
        if (rx_ferror) fe_cnt++;
        if (data !== data_prev && !word_valid && !rst_seen) stray_change++;
        wv_prev   = word_valid;
        data_prev = data;
    end

    // Frame-level reference model.
    logic        m_held;
    logic [7:0]  m_low;
    logic [15:0] m_data;
    int          m_wv, m_pe, m_fe;

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) begin
            m_pe  += int'(bad_par);
            m_fe  += int'(bad_stop);
            m_held = 1'b0;
        end else if (m_held) begin
            m_data = {b, m_low};
            m_wv++;
            m_held = 1'b0;
        end else begin
            m_low  = b;
            m_held = 1'b1;
        end
    endtask

    // Idle stretches are either well under or well over the gap limit.
    task automatic model_idle(input int bits);
        if (bits > GAP_BITS + 1) m_held = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_clks(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // baud_select is scrambled mid-frame; the receiver must keep the rate latched at the start edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        baud_select = 3'd7;
        drive_bit(1'b0);
        baud_select = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit((^b) ^ bad_par);
        baud_select = 3'd7;
        drive_bit(~bad_stop);
        RxD = 1'b1;
        model_frame(b, bad_par, bad_stop);
    endtask

    task automatic partial_frame();
        int k;
        k = $urandom_range(1, 6);
        drive_bit(1'b0);
        for (int i = 0; i < k; i++) drive_bit(1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, BIT_CLKS - 1)) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        #1;
        check({tag, " word_valid count"}, wv_cnt, m_wv);
        check({tag, " perror count"}, pe_cnt, m_pe);
        check({tag, " ferror count"}, fe_cnt, m_fe);
        check({tag, " data"}, data, m_data);
        check({tag, " busy"}, busy, m_held);
        check({tag, " word_valid width"}, wv_long, 0);
        check({tag, " data stray change"}, stray_change, 0);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " data"}, data, 16'h0000);
        check({tag, " word_valid"}, word_valid, 1'b0);
        check({tag, " perror"}, rx_perror, 1'b0);
        check({tag, " ferror"}, rx_ferror, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 150000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        reset       = 1'b1;
        RX_EN       = 1'b1;
        RxD         = 1'b1;
        baud_select = 3'd7;
        m_held      = 1'b0;
        m_low       = '0;
        m_data      = '0;
        m_wv        = 0;
        m_pe        = 0;
        m_fe        = 0;

        repeat (4) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Word reassembly.
        idle_clks(2 * BIT_CLKS);
        send_frame(8'h10, 1'b0, 1'b0);
        send_frame(8'hCC, 1'b0, 1'b0);
        check_state("word_cc10");

        // Parity error clears the holder; next good pair still assembles.
        idle_clks($urandom_range(20, 300));
        send_frame(8'h10, 1'b1, 1'b0);
        check_state("parity_err");
        idle_clks($urandom_range(20, 300));
        send_frame(8'h34, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        check_state("word_1234");

        // Framing error on the high byte.
        idle_clks($urandom_range(20, 300));
        send_frame(8'hAB, 1'b0, 1'b0);
        send_frame(8'hCD, 1'b0, 1'b1);
        check_state("framing_err");

        // False start: 135 clk low glitch.
        idle_clks(BIT_CLKS);
        RxD = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("false_start busy during", busy, 1'b1);
        repeat (35) @(negedge clk);
        idle_clks(BIT_CLKS);
        check_state("false_start");

        // Gap timeout drops the held low byte.
        send_frame(8'h11, 1'b0, 1'b0);
        check_state("gap_held");
        gap = $urandom_range(36, 38);
        idle_clks(gap * BIT_CLKS);
        model_idle(gap);
        check_state("gap_expired");
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        check_state("word_3322");

        // RX_EN dropped mid-frame.
        idle_clks($urandom_range(20, 300));
        partial_frame();
        RX_EN  = 1'b0;
        RxD    = 1'b1;
        m_held = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        check_state("rxen_abort");
        RX_EN = 1'b1;
        idle_clks(BIT_CLKS);
        send_frame(8'hEF, 1'b0, 1'b0);
        send_frame(8'hBE, 1'b0, 1'b0);
        check_state("rxen_beef");

        // Reset pulsed mid-frame.
        idle_clks($urandom_range(20, 300));
        partial_frame();
        RxD   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_outputs_zero("mid_reset");
        reset  = 1'b0;
        m_held = 1'b0;
        m_data = '0;
        idle_clks(BIT_CLKS);
        check_state("after_reset");
        send_frame(8'hEF, 1'b0, 1'b0);
        send_frame(8'hBE, 1'b0, 1'b0);
        check_state("reset_beef");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
